// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    localparam int PKG_PC_W   = 64;
    localparam int PKG_ADDR_W = 6;

    // Byte size of a word-addressed ROM with the given address width.
    function automatic logic [63:0] rom_bytes(input int addr_w);
        return 64'd4 << addr_w;
    endfunction

    localparam logic [63:0] ROM_BYTES = rom_bytes(PKG_ADDR_W);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PKG_PC_W-1:0] pc;
        logic                fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of fetch entries with a registered head entry.
// Flush wins over push and pop. The head register always holds the entry
// that sits at the front of the queue, so consumers see no RAM read path.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               din,
    output fetch_entry_t               head,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [CNT_W-1:0]   count_after_pop;
    fetch_entry_t       head_reg, head_next;
    logic               valid_reg;
    logic               do_pop, do_push;

    // Qualify handshakes: never pop an empty queue, never overfill.
    always_comb begin
        do_pop  = pop && (count_reg != '0);
        do_push = push && ((count_reg < CNT_W'(DEPTH)) || do_pop);
    end

    // Next pointers, occupancy and head entry.
    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        head_next       = head_reg;
        count_after_pop = count_reg - CNT_W'(do_pop);
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            count_next = count_after_pop + CNT_W'(do_push);
            // An empty (or emptying) queue takes its new head straight from
            // the incoming word; otherwise the next stored entry moves up.
            if (count_after_pop == '0) begin
                if (do_push) head_next = din;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    // Storage write; no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= din;
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
            valid_reg  <= (count_next != '0);
        end
    end

    assign head  = head_reg;
    assign valid = valid_reg;
    assign count = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, reads the ROM, queues
// words with their PCs, turns bad PCs into fault entries and halts there
// until a redirect arrives.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                PC_W     = PKG_PC_W,
    parameter int                ADDR_W   = PKG_ADDR_W,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [31:0]                imem_q,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic                       out_fault,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int              CNT_W     = $clog2(DEPTH) + 1;
    // Entry pc field is sized by the package; PC_W must match it.
    localparam logic [PC_W-1:0] ROM_LIMIT = PC_W'(rom_bytes(ADDR_W));

    fetch_state_t       state_reg;
    logic [PC_W-1:0]    fetch_pc_reg;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;
    logic               fifo_valid;
    logic [CNT_W-1:0]   fifo_count;
    logic               pop, can_push, push, pc_fault;

    // Push/pop decisions and the entry formed from the current fetch PC.
    always_comb begin
        pop        = fifo_valid && out_ready;
        can_push   = (fifo_count < CNT_W'(DEPTH)) || pop;
        pc_fault   = (fetch_pc_reg[1:0] != 2'b00) || (fetch_pc_reg >= ROM_LIMIT);
        push       = (state_reg == FETCH) && can_push && !redirect_valid;
        push_entry.pc    = fetch_pc_reg;
        push_entry.fault = pc_fault;
        push_entry.instr = pc_fault ? 32'h0 : imem_q;
    end

    // Fetch FSM: PC advance, fault halt, redirect restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= FETCH;
            fetch_pc_reg <= RESET_PC;
        end else if (redirect_valid) begin
            state_reg    <= FETCH;
            fetch_pc_reg <= redirect_pc;
        end else if (state_reg == FETCH && can_push) begin
            if (pc_fault) begin
                state_reg <= HALT;
            end else begin
                fetch_pc_reg <= fetch_pc_reg + PC_W'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .head  (head_entry),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign imem_addr = fetch_pc_reg[ADDR_W+1:2];
    assign out_valid = fifo_valid;
    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;
    assign out_fault = head_entry.fault;
    assign q_count   = fifo_count;

endmodule
